// File: rtl/sa_mem_sequencer.sv
// Memory sequencer for a systolic array: loads weights, streams input rows
// (optionally with partial sums), and writes result rows to the output buffer.
module sa_mem_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = 256,
  parameter int I_SIZE = 256,
  parameter int O_SIZE = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rstn_async_i,
  input  logic                                      start_i,
  input  logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0]  w_rows_i,
  input  logic [$clog2(I_SIZE)-1:0]                 i_rows_i,
  input  logic [$clog2(W_SIZE)-1:0]                 w_offset_i,
  input  logic [$clog2(I_SIZE)-1:0]                 i_offset_i,
  input  logic [$clog2(O_SIZE)-1:0]                 psum_offset_i,
  input  logic [$clog2(O_SIZE)-1:0]                 o_offset_i,
  input  logic                                      accum_en_i,
  input  logic                                      array_valid_i,
  output logic                                      wb_mem_cenb_o,
  output logic                                      ib_mem_cenb_o,
  output logic                                      ps_mem_cenb_o,
  output logic [$clog2(W_SIZE)-1:0]                 wb_mem_addr_o,
  output logic [$clog2(I_SIZE)-1:0]                 ib_mem_addr_o,
  output logic [$clog2(O_SIZE)-1:0]                 ps_mem_addr_o,
  output logic                                      ob_mem_cenb_o,
  output logic                                      ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0]                 ob_mem_addr_o,
  output logic                                      weight_en_o,
  output logic                                      valid_o,
  output logic                                      busy_o,
  output logic                                      done_o
);

  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int OAW = $clog2(O_SIZE);
  localparam int CW  = IAW + 1;

  // Data width and column count only shape the array itself; nothing to build here.
  if (WIDTH < 1 || COL < 1) begin : g_invalid_cfg
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [RW-1:0]    r_w_rows;
  logic [IAW-1:0]   r_i_rows;
  logic [WAW-1:0]   r_w_offset;
  logic [IAW-1:0]   r_i_offset;
  logic [OAW-1:0]   r_psum_offset;
  logic [OAW-1:0]   r_o_offset;
  logic             r_accum_en;

  logic [RW-1:0]    r_wcnt;
  logic [IAW-1:0]   r_icnt;
  logic [CW-1:0]    r_ocnt;
  logic             r_weight_en;
  logic             r_valid;

  logic             w_start;
  logic             w_ob_wr;
  logic [CW-1:0]    w_target;
  logic [CW-1:0]    w_ocnt_nxt;
  logic             w_load_last;
  logic             w_stream_last;

  assign w_start       = (r_state == S_IDLE) && start_i;
  assign w_target      = {1'b0, r_i_rows} + CW'(1);
  assign w_load_last   = (r_wcnt == r_w_rows);
  assign w_stream_last = (r_icnt == r_i_rows);
  // Result rows are accepted once the job is streaming; rows beyond the expected
  // count (e.g. array_valid_i still high in DONE) are dropped so the buffer is
  // never written past the job's output region.
  assign w_ob_wr       = array_valid_i && (r_ocnt != w_target) &&
                         ((r_state == S_STREAM) || (r_state == S_DRAIN) || (r_state == S_DONE));
  assign w_ocnt_nxt    = r_ocnt + CW'(w_ob_wr);

  // State register
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next-state logic; drain exit looks at the post-write count so DONE follows the last write directly
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_nxt = S_LOAD_W;
      S_LOAD_W: if (w_load_last) w_state_nxt = S_STREAM;
      S_STREAM: if (w_stream_last) w_state_nxt = (w_ocnt_nxt == w_target) ? S_DONE : S_DRAIN;
      S_DRAIN:  if (w_ocnt_nxt == w_target) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; everything inactive unless the current state drives it
  always_comb begin
    wb_mem_cenb_o = 1'b1;
    ib_mem_cenb_o = 1'b1;
    ps_mem_cenb_o = 1'b1;
    wb_mem_addr_o = '0;
    ib_mem_addr_o = '0;
    ps_mem_addr_o = '0;
    ob_mem_cenb_o = 1'b1;
    ob_mem_wenb_o = 1'b1;
    ob_mem_addr_o = '0;
    busy_o        = (r_state != S_IDLE);
    done_o        = (r_state == S_DONE);
    case (r_state)
      S_LOAD_W: begin
        wb_mem_cenb_o = 1'b0;
        wb_mem_addr_o = r_w_offset + WAW'(r_wcnt);
      end
      S_STREAM: begin
        ib_mem_cenb_o = 1'b0;
        ib_mem_addr_o = r_i_offset + r_icnt;
        if (r_accum_en) begin
          ps_mem_cenb_o = 1'b0;
          ps_mem_addr_o = r_psum_offset + OAW'(r_icnt);
        end
      end
      default: ;
    endcase
    if (w_ob_wr) begin
      ob_mem_cenb_o = 1'b0;
      ob_mem_wenb_o = 1'b0;
      ob_mem_addr_o = r_o_offset + OAW'(r_ocnt);
    end
  end

  // Configuration latch and job counters, cleared on each accepted start
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      r_w_rows      <= '0;
      r_i_rows      <= '0;
      r_w_offset    <= '0;
      r_i_offset    <= '0;
      r_psum_offset <= '0;
      r_o_offset    <= '0;
      r_accum_en    <= 1'b0;
      r_wcnt        <= '0;
      r_icnt        <= '0;
      r_ocnt        <= '0;
    end else if (w_start) begin
      r_w_rows      <= w_rows_i;
      r_i_rows      <= i_rows_i;
      r_w_offset    <= w_offset_i;
      r_i_offset    <= i_offset_i;
      r_psum_offset <= psum_offset_i;
      r_o_offset    <= o_offset_i;
      r_accum_en    <= accum_en_i;
      r_wcnt        <= '0;
      r_icnt        <= '0;
      r_ocnt        <= '0;
    end else begin
      if (r_state == S_LOAD_W) r_wcnt <= r_wcnt + RW'(1);
      if (r_state == S_STREAM) r_icnt <= r_icnt + IAW'(1);
      r_ocnt <= w_ocnt_nxt;
    end
  end

  // Array strobes follow the read enables by the one-cycle memory latency
  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      r_weight_en <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_weight_en <= (r_state == S_LOAD_W);
      r_valid     <= (r_state == S_STREAM);
    end
  end

  assign weight_en_o = r_weight_en;
  assign valid_o     = r_valid;

endmodule

// File: tb/tb_sa_mem_sequencer.sv
// Directed bench for sa_mem_sequencer: full jobs with and without psum reads,
// address wrap, ignored restart, async abort and early completion.
module tb_sa_mem_sequencer;

  logic       clk_i = 1'b0;
  logic       rstn_async_i;
  logic       start_i;
  logic [1:0] w_rows_i;
  logic [7:0] i_rows_i, w_offset_i, i_offset_i, psum_offset_i, o_offset_i;
  logic       accum_en_i, array_valid_i;
  logic       wb_mem_cenb_o, ib_mem_cenb_o, ps_mem_cenb_o;
  logic [7:0] wb_mem_addr_o, ib_mem_addr_o, ps_mem_addr_o;
  logic       ob_mem_cenb_o, ob_mem_wenb_o;
  logic [7:0] ob_mem_addr_o;
  logic       weight_en_o, valid_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  sa_mem_sequencer dut (
    .clk_i(clk_i), .rstn_async_i(rstn_async_i), .start_i(start_i),
    .w_rows_i(w_rows_i), .i_rows_i(i_rows_i), .w_offset_i(w_offset_i),
    .i_offset_i(i_offset_i), .psum_offset_i(psum_offset_i), .o_offset_i(o_offset_i),
    .accum_en_i(accum_en_i), .array_valid_i(array_valid_i),
    .wb_mem_cenb_o(wb_mem_cenb_o), .ib_mem_cenb_o(ib_mem_cenb_o), .ps_mem_cenb_o(ps_mem_cenb_o),
    .wb_mem_addr_o(wb_mem_addr_o), .ib_mem_addr_o(ib_mem_addr_o), .ps_mem_addr_o(ps_mem_addr_o),
    .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o), .ob_mem_addr_o(ob_mem_addr_o),
    .weight_en_o(weight_en_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " wb_cenb"}, wb_mem_cenb_o, 1);
    check({tag, " ib_cenb"}, ib_mem_cenb_o, 1);
    check({tag, " ps_cenb"}, ps_mem_cenb_o, 1);
    check({tag, " ob_cenb"}, ob_mem_cenb_o, 1);
    check({tag, " ob_wenb"}, ob_mem_wenb_o, 1);
    check({tag, " addrs"}, {wb_mem_addr_o, ib_mem_addr_o, ps_mem_addr_o, ob_mem_addr_o}, 0);
    check({tag, " busy"}, busy_o, 0);
    check({tag, " done"}, done_o, 0);
  endtask

  // Runs one job from a negedge; the drain phase pulses array_valid_i ir+1 times.
  task automatic run_job(input string tag, input logic [1:0] wr, input logic [7:0] ir,
                         input logic [7:0] woff, input logic [7:0] ioff, input logic [7:0] psoff,
                         input logic [7:0] ooff, input logic acc, input int restart_at,
                         input bit gaps);
    logic [7:0] e;
    w_rows_i = wr; i_rows_i = ir; w_offset_i = woff; i_offset_i = ioff;
    psum_offset_i = psoff; o_offset_i = ooff; accum_en_i = acc; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    // scramble the inputs to show the configuration was latched
    w_offset_i = 8'h55; i_offset_i = 8'h66; o_offset_i = 8'h77; accum_en_i = ~acc;
    for (int k = 0; k <= int'(wr); k++) begin
      e = woff + 8'(k);
      check({tag, " ld wb_cenb"}, wb_mem_cenb_o, 0);
      check({tag, " ld wb_addr"}, wb_mem_addr_o, e);
      check({tag, " ld weight_en"}, weight_en_o, (k != 0));
      check({tag, " ld ib_cenb"}, ib_mem_cenb_o, 1);
      check({tag, " ld busy"}, busy_o, 1);
      @(negedge clk_i);
    end
    for (int n = 0; n <= int'(ir); n++) begin
      start_i = (n == restart_at);
      e = ioff + 8'(n);
      check({tag, " st ib_cenb"}, ib_mem_cenb_o, 0);
      check({tag, " st ib_addr"}, ib_mem_addr_o, e);
      check({tag, " st ps_cenb"}, ps_mem_cenb_o, !acc);
      e = acc ? (psoff + 8'(n)) : 8'h00;
      check({tag, " st ps_addr"}, ps_mem_addr_o, e);
      check({tag, " st valid"}, valid_o, (n != 0));
      check({tag, " st weight_en"}, weight_en_o, (n == 0));
      check({tag, " st wb_cenb"}, wb_mem_cenb_o, 1);
      check({tag, " st done"}, done_o, 0);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check({tag, " dr valid"}, valid_o, 1);
    check({tag, " dr ib_cenb"}, ib_mem_cenb_o, 1);
    for (int j = 0; j <= int'(ir); j++) begin
      array_valid_i = 1'b1;
      #1;
      e = ooff + 8'(j);
      check({tag, " dr ob_cenb"}, ob_mem_cenb_o, 0);
      check({tag, " dr ob_wenb"}, ob_mem_wenb_o, 0);
      check({tag, " dr ob_addr"}, ob_mem_addr_o, e);
      check({tag, " dr done"}, done_o, 0);
      @(negedge clk_i);
      array_valid_i = 1'b0;
      if (gaps && j != int'(ir)) begin
        #1;
        check({tag, " gap ob_cenb"}, ob_mem_cenb_o, 1);
        check({tag, " gap done"}, done_o, 0);
        @(negedge clk_i);
      end
    end
    check({tag, " done pulse"}, done_o, 1);
    check({tag, " done busy"}, busy_o, 1);
    check({tag, " done ob_cenb"}, ob_mem_cenb_o, 1);
    @(negedge clk_i);
    check_idle({tag, " post"});
  endtask

  initial begin
    rstn_async_i = 1'b0; start_i = 1'b0; w_rows_i = '0; i_rows_i = '0;
    w_offset_i = '0; i_offset_i = '0; psum_offset_i = '0; o_offset_i = '0;
    accum_en_i = 1'b0; array_valid_i = 1'b0;
    #2;
    check_idle("reset");
    check("reset weight_en", weight_en_o, 0);
    check("reset valid", valid_o, 0);
    @(negedge clk_i);
    rstn_async_i = 1'b1;
    @(negedge clk_i);
    // array_valid_i in IDLE must not write
    array_valid_i = 1'b1; #1;
    check("idle ob_cenb", ob_mem_cenb_o, 1);
    @(negedge clk_i);
    array_valid_i = 1'b0;

    run_job("basic",   2'd3, 8'd7, 8'h10, 8'h20, 8'h40, 8'h80, 1'b0, -1, 1'b0);
    run_job("accum",   2'd3, 8'd7, 8'h10, 8'h20, 8'h40, 8'h80, 1'b1, -1, 1'b0);
    run_job("owrap",   2'd1, 8'd3, 8'hFF, 8'h00, 8'h00, 8'hFE, 1'b0, -1, 1'b1);
    run_job("restart", 2'd2, 8'd5, 8'h30, 8'hFD, 8'hFC, 8'h10, 1'b1, 2, 1'b0);

    // async abort in the middle of LOAD_W
    w_rows_i = 2'd3; i_rows_i = 8'd2; w_offset_i = 8'h08; accum_en_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("abort pre wb_addr", wb_mem_addr_o, 8'h09);
    check("abort pre weight_en", weight_en_o, 1);
    #2 rstn_async_i = 1'b0;
    #1;
    check_idle("abort");
    check("abort weight_en", weight_en_o, 0);
    @(negedge clk_i);
    check("abort held busy", busy_o, 0);
    check("abort held wb_cenb", wb_mem_cenb_o, 1);
    rstn_async_i = 1'b1;
    @(negedge clk_i);
    run_job("after_abort", 2'd3, 8'd2, 8'h08, 8'h18, 8'h00, 8'h28, 1'b0, -1, 1'b0);

    // i_rows=0 with array_valid_i held high from STREAM entry
    w_rows_i = 2'd0; i_rows_i = 8'd0; w_offset_i = 8'h01; i_offset_i = 8'h02;
    o_offset_i = 8'h33; accum_en_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("early ld wb_addr", wb_mem_addr_o, 8'h01);
    @(negedge clk_i);
    array_valid_i = 1'b1; #1;
    check("early st ib_addr", ib_mem_addr_o, 8'h02);
    check("early ob_cenb", ob_mem_cenb_o, 0);
    check("early ob_addr", ob_mem_addr_o, 8'h33);
    @(negedge clk_i); #1;
    check("early done", done_o, 1);
    check("early no 2nd write", ob_mem_cenb_o, 1);
    @(negedge clk_i); #1;
    check("early idle busy", busy_o, 0);
    check("early idle no write", ob_mem_cenb_o, 1);
    check("early idle done", done_o, 0);
    @(negedge clk_i); #1;
    check("early idle2 no write", ob_mem_wenb_o, 1);
    array_valid_i = 1'b0;
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
